ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, event-FIFO entry count (power of two, >=2).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 code  input  8  PS/2 scan-code byte from the upstream receiver, qualified by code_valid.
REQ-005 code_valid  input  1  one-cycle pulse; code is a checked byte (start, stop and parity good).
REQ-006 key_down  output  1  high while the last pressed non-extended key is held.
REQ-007 cur_code  output  8  make code of the last pressed key.
REQ-008 ascii  output  8  lowercase ASCII of cur_code; 0x00 if unmapped.
REQ-009 press_cnt  output  8  count of distinct key presses, wraps.
REQ-010 ev_valid  output  1  event FIFO non-empty.
REQ-011 ev_data  output  10  head event {brk, ext, code[7:0]}.
REQ-012 ev_ready  input  1  consumer pop; an entry pops on a cycle with ev_valid & ev_ready.
REQ-013 overflow  output  1  sticky: an event was dropped.

Function
REQ-014 Parser FSM states: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (after 0xE0,0xF0); the FSM advances only on cycles with code_valid=1.
REQ-015 Transitions: IDLE -0xE0-> EXT; IDLE -0xF0-> BRK; EXT -0xF0-> EXT_BRK; any other byte completes an event and returns to IDLE.
REQ-016 A completed event has brk=1 from BRK or EXT_BRK, and brk=0 otherwise; ext=1 from EXT or EXT_BRK, and ext=0 otherwise; its code field is the completing byte.
REQ-017 0xE0 in EXT or EXT_BRK, and 0xF0 in BRK or EXT_BRK, keep the current state and push no event.
REQ-018 Non-extended make, code != cur_code or key_down=0: next edge sets cur_code=code and key_down=1, increments press_cnt and pushes the event.
REQ-019 Non-extended make, code == cur_code and key_down=1 (typematic repeat): no state, count or FIFO change.
REQ-020 Non-extended break, code == cur_code: key_down=0, cur_code held, event pushed. Break of any other code: event pushed, key_down unchanged.
REQ-021 Extended events (make or break) are pushed only and never alter key_down, cur_code or press_cnt.
REQ-022 ascii is combinational from cur_code. Digits: 0x45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'.
REQ-023 Letters 'a'..'z': 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A. All other codes map to 0x00.
REQ-024 Latency: code_valid at edge N -> outputs and FIFO write visible after edge N+1; ev_valid rises 1 cycle after the completing byte.
REQ-025 FIFO is first-word-fall-through: ev_data is valid whenever ev_valid=1 and is stable until popped.
REQ-026 Push when full with no pop: event dropped, overflow=1 until reset.
REQ-027 Push and pop in the same cycle: always accepted, including when full; occupancy unchanged.
REQ-028 Pop when empty is ignored. press_cnt wraps 0xFF -> 0x00.

Reset
REQ-029 resetn=0 at posedge clk: FSM=IDLE, FIFO emptied.
REQ-030 On that edge: key_down=0, cur_code=0x00, press_cnt=0, ev_valid=0, overflow=0.
REQ-031 Reset takes priority over a simultaneous code_valid.
REQ-032 Reset between prefix and final byte discards the partial sequence; the next byte is parsed from IDLE.

Verification
REQ-033 Stream 0x1C, 0xF0, 0x1C with ev_ready=1 -> events 0x01C then 0x21C; after byte 1 key_down=1, ascii=0x61, press_cnt=1; after byte 3 key_down=0.
REQ-034 Stream 0x1C, 0x1C, 0x1C -> one event only; press_cnt=1.
REQ-035 Stream 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> events 0x175, 0x375; key_down, cur_code and press_cnt unchanged.
REQ-036 ev_ready=0, FIFO_DEPTH=4, five distinct makes -> first four events retained in order, overflow=1. Then a push with a simultaneous pop is accepted.
REQ-037 Reset asserted after 0xF0 and before its code, then stream 0x45 -> make event 0x045, ascii=0x30, press_cnt=1.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
//
// Turns a stream of checked PS/2 scan-code bytes into key events. A small
// parser tracks the 0xE0 (extended) and 0xF0 (break) prefixes. It maintains
// the state of the last pressed non-extended key and a press counter, and it
// queues every completed event in a first-word-fall-through FIFO.
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   resetn      synchronous active-low reset
//   code        scan-code byte, qualified by code_valid
//   code_valid  one-cycle strobe marking a good byte on code
//   key_down    last pressed non-extended key is still held
//   cur_code    make code of the last pressed non-extended key
//   ascii       lowercase ASCII for cur_code (0x00 when unmapped)
//   press_cnt   wrapping count of distinct key presses
//   ev_valid    event FIFO holds at least one entry
//   ev_data     head event {brk, ext, code[7:0]}
//   ev_ready    consumer pops the head when ev_valid is also high
//   overflow    sticky flag, set when an event was dropped on a full FIFO
// ----------------------------------------------------------------------------
module ps2_key_decoder #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] code,
   input  logic       code_valid,
   output logic       key_down,
   output logic [7:0] cur_code,
   output logic [7:0] ascii,
   output logic [7:0] press_cnt,
   output logic       ev_valid,
   output logic [9:0] ev_data,
   input  logic       ev_ready,
   output logic       overflow
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   // Parser states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   logic [1:0] state_q, state_d;

   logic       key_down_q, key_down_d;
   logic [7:0] cur_code_q, cur_code_d;
   logic [7:0] press_cnt_q, press_cnt_d;
   logic       overflow_q, overflow_d;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [9:0]    mem_q [FIFO_DEPTH];

   // Completed-event descriptor from the parser
   logic ev_done;
   logic done_brk;
   logic done_ext;

   logic push_req;
   logic push_ok;
   logic pop;
   logic full;

   // -------------------------------------------------------------------------
   // Prefix parser
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ev_done  = 1'b0;
      done_brk = 1'b0;
      done_ext = 1'b0;
      if (code_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (code == CODE_EXT) begin
                  state_d = ST_EXT;
               end else if (code == CODE_BRK) begin
                  state_d = ST_BRK;
               end else begin
                  ev_done = 1'b1;
               end
            end
            ST_EXT: begin
               if (code == CODE_BRK) begin
                  state_d = ST_EXT_BRK;
               end else if (code != CODE_EXT) begin
                  // A repeated 0xE0 keeps waiting for the real code
                  ev_done  = 1'b1;
                  done_ext = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_BRK: begin
               // Only 0xF0 is absorbed here; 0xE0 completes a break event
               if (code != CODE_BRK) begin
                  ev_done  = 1'b1;
                  done_brk = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if ((code != CODE_EXT) && (code != CODE_BRK)) begin
                  ev_done  = 1'b1;
                  done_brk = 1'b1;
                  done_ext = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Key state and event push decision
   // -------------------------------------------------------------------------
   always_comb begin
      key_down_d  = key_down_q;
      cur_code_d  = cur_code_q;
      press_cnt_d = press_cnt_q;
      push_req    = 1'b0;
      if (ev_done) begin
         if (done_ext) begin
            // Extended keys are reported but never tracked
            push_req = 1'b1;
         end else if (done_brk) begin
            if (code == cur_code_q) begin
               key_down_d = 1'b0;
            end
            push_req = 1'b1;
         end else if ((code != cur_code_q) || !key_down_q) begin
            // Typematic repeats of the held key fall outside this branch
            key_down_d  = 1'b1;
            cur_code_d  = code;
            press_cnt_d = press_cnt_q + 8'd1;
            push_req    = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Event FIFO (first-word-fall-through)
   // -------------------------------------------------------------------------
   assign ev_valid = (count_q != '0);
   assign full     = (count_q == FULL_CNT);
   assign pop      = ev_valid & ev_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_ok  = push_req & (~full | pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (push_req & ~push_ok);
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {done_brk, done_ext, code};
      end
   end

   assign ev_data = mem_q[rd_ptr_q];

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         key_down_q  <= 1'b0;
         cur_code_q  <= 8'h00;
         press_cnt_q <= 8'h00;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         key_down_q  <= key_down_d;
         cur_code_q  <= cur_code_d;
         press_cnt_q <= press_cnt_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   assign key_down  = key_down_q;
   assign cur_code  = cur_code_q;
   assign press_cnt = press_cnt_q;
   assign overflow  = overflow_q;

   // -------------------------------------------------------------------------
   // Scan code set 2 to lowercase ASCII
   // -------------------------------------------------------------------------
   always_comb begin
      ascii = 8'h00;
      case (cur_code_q)
         8'h45: ascii = 8'h30; // 0
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39; // 9
         8'h1C: ascii = 8'h61; // a
         8'h32: ascii = 8'h62;
         8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;
         8'h24: ascii = 8'h65;
         8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;
         8'h33: ascii = 8'h68;
         8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;
         8'h42: ascii = 8'h6B;
         8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;
         8'h31: ascii = 8'h6E;
         8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;
         8'h15: ascii = 8'h71;
         8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;
         8'h2C: ascii = 8'h74;
         8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;
         8'h1D: ascii = 8'h77;
         8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;
         8'h1A: ascii = 8'h7A; // z
         default: ascii = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Directed bench for ps2_key_decoder. Inputs change 1 time unit after a
// rising edge, events are logged on the falling edge whenever a pop is about
// to happen, and all results go through check_eq.
// ----------------------------------------------------------------------------
module tb_ps2_key_decoder;

   logic       clk;
   logic       resetn;
   logic [7:0] code;
   logic       code_valid;
   logic       key_down;
   logic [7:0] cur_code;
   logic [7:0] ascii;
   logic [7:0] press_cnt;
   logic       ev_valid;
   logic [9:0] ev_data;
   logic       ev_ready;
   logic       overflow;

   int unsigned n_checks;
   int unsigned n_fails;
   logic [9:0]  ev_log [$];

   ps2_key_decoder #(
      .FIFO_DEPTH(4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .code      (code),
      .code_valid(code_valid),
      .key_down  (key_down),
      .cur_code  (cur_code),
      .ascii     (ascii),
      .press_cnt (press_cnt),
      .ev_valid  (ev_valid),
      .ev_data   (ev_data),
      .ev_ready  (ev_ready),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every entry that the next rising edge will pop
   always @(negedge clk) begin
      if (resetn && ev_valid && ev_ready) begin
         ev_log.push_back(ev_data);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn     = 1'b0;
      code_valid = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      ev_log.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      code       = b;
      code_valid = 1'b1;
      tick();
      code_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   logic [9:0] exp_ev [5];

   initial begin
      n_checks   = 0;
      n_fails    = 0;
      resetn     = 1'b1;
      code       = 8'h00;
      code_valid = 1'b0;
      ev_ready   = 1'b0;
      #1;

      // Reset wins over a simultaneous byte
      resetn     = 1'b0;
      code       = 8'h1C;
      code_valid = 1'b1;
      tick();
      tick();
      code_valid = 1'b0;
      resetn     = 1'b1;
      check_eq("rst_key_down", 32'(key_down), 32'h0);
      check_eq("rst_cur_code", 32'(cur_code), 32'h00);
      check_eq("rst_press_cnt", 32'(press_cnt), 32'h00);
      check_eq("rst_ev_valid", 32'(ev_valid), 32'h0);
      check_eq("rst_overflow", 32'(overflow), 32'h0);
      check_eq("rst_ascii", 32'(ascii), 32'h00);

      // Make then break of 'a'
      do_reset();
      ev_ready = 1'b1;
      send_byte(8'h1C);
      check_eq("a_key_down", 32'(key_down), 32'h1);
      check_eq("a_ascii", 32'(ascii), 32'h61);
      check_eq("a_press_cnt", 32'(press_cnt), 32'h01);
      check_eq("a_ev_valid", 32'(ev_valid), 32'h1);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check_eq("a_brk_key_down", 32'(key_down), 32'h0);
      check_eq("a_brk_cur_code", 32'(cur_code), 32'h1C);
      idle(2);
      check_eq("a_ev_count", ev_log.size(), 2);
      check_eq("a_ev0", 32'(ev_log[0]), 32'h01C);
      check_eq("a_ev1", 32'(ev_log[1]), 32'h21C);
      check_eq("a_drained", 32'(ev_valid), 32'h0);

      // Typematic repeat
      do_reset();
      ev_ready = 1'b1;
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      idle(2);
      check_eq("rep_press_cnt", 32'(press_cnt), 32'h01);
      check_eq("rep_ev_count", ev_log.size(), 1);
      check_eq("rep_ev0", 32'(ev_log[0]), 32'h01C);

      // Extended keys and a break of a different key leave key state alone
      do_reset();
      ev_ready = 1'b1;
      send_byte(8'h1C);
      send_byte(8'hE0);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      send_byte(8'hF0);
      send_byte(8'h32);
      idle(2);
      check_eq("ext_key_down", 32'(key_down), 32'h1);
      check_eq("ext_cur_code", 32'(cur_code), 32'h1C);
      check_eq("ext_press_cnt", 32'(press_cnt), 32'h01);
      check_eq("ext_ev_count", ev_log.size(), 4);
      check_eq("ext_ev0", 32'(ev_log[0]), 32'h01C);
      check_eq("ext_ev1", 32'(ev_log[1]), 32'h175);
      check_eq("ext_ev2", 32'(ev_log[2]), 32'h375);
      check_eq("ext_ev3", 32'(ev_log[3]), 32'h232);

      // Overflow with no consumer, then push with simultaneous pop on full
      do_reset();
      ev_ready = 1'b0;
      send_byte(8'h16);
      send_byte(8'h1E);
      send_byte(8'h26);
      send_byte(8'h25);
      check_eq("ovf_not_yet", 32'(overflow), 32'h0);
      send_byte(8'h2E);
      check_eq("ovf_set", 32'(overflow), 32'h1);
      check_eq("ovf_head", 32'(ev_data), 32'h016);
      check_eq("ovf_press_cnt", 32'(press_cnt), 32'h05);
      idle(3);
      check_eq("ovf_head_stable", 32'(ev_data), 32'h016);
      ev_ready = 1'b1;
      send_byte(8'h36);
      ev_ready = 1'b0;
      check_eq("ovf_after_pp_valid", 32'(ev_valid), 32'h1);
      check_eq("ovf_after_pp_head", 32'(ev_data), 32'h01E);
      ev_ready = 1'b1;
      idle(6);
      exp_ev[0] = 10'h016;
      exp_ev[1] = 10'h01E;
      exp_ev[2] = 10'h026;
      exp_ev[3] = 10'h025;
      exp_ev[4] = 10'h036;
      check_eq("ovf_ev_count", ev_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("ovf_ev%0d", i), 32'(ev_log[i]), 32'(exp_ev[i]));
      end
      check_eq("ovf_sticky", 32'(overflow), 32'h1);
      check_eq("ovf_empty_pop", 32'(ev_valid), 32'h0);

      // Reset in the middle of a break sequence
      do_reset();
      send_byte(8'hF0);
      do_reset();
      ev_ready = 1'b1;
      send_byte(8'h45);
      check_eq("mid_ascii", 32'(ascii), 32'h30);
      check_eq("mid_press_cnt", 32'(press_cnt), 32'h01);
      check_eq("mid_key_down", 32'(key_down), 32'h1);
      idle(2);
      check_eq("mid_ev_count", ev_log.size(), 1);
      check_eq("mid_ev0", 32'(ev_log[0]), 32'h045);
      check_eq("mid_overflow", 32'(overflow), 32'h0);

      // press_cnt wraps after 256 distinct presses
      do_reset();
      ev_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
      end
      check_eq("wrap_ff", 32'(press_cnt), 32'hFF);
      check_eq("wrap_ascii_a", 32'(ascii), 32'h61);
      send_byte(8'h32);
      check_eq("wrap_00", 32'(press_cnt), 32'h00);
      check_eq("wrap_ascii_b", 32'(ascii), 32'h62);
      idle(2);
      check_eq("wrap_no_ovf", 32'(overflow), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
